// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BURST)
//   rr_next     : modular increment of a round-robin pointer
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Advance a pointer by one, wrapping from n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (ptr >= (n - 32'd1)) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Returns the first set bit of
// req when searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  IDW      index with highest priority
//   idx    out IDW      selected index (0 when nothing is found)
//   found  out 1        at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     idx,
  output logic               found
);

  logic [IDW-1:0] cand_s;

  // Walk the ring starting at rr_ptr; the first hit wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    cand_s = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand_s]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
      end
      cand_s = IDW'(rr_next(32'(cand_s), NUM_REQ));
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Shares one FIFO write port among NUM_REQ producers using round-robin
// arbitration with bursts of at most BURST_MAX beats. The winning beat is
// registered into a one-entry output stage, so the FIFO sees a registered
// write_en/write_data pair.
//
// Ports:
//   CLK             in   1               clock, posedge
//   RST             in   1               synchronous active-high reset
//   req_valid       in   NUM_REQ         requester i has a beat
//   req_data        in   NUM_REQ*DATA_W  beat of requester i at [i*DATA_W +: DATA_W]
//   req_ack         out  NUM_REQ         one-hot, combinational: beat consumed
//   fifo_write_en   out  1               registered: output stage holds a beat
//   fifo_write_data out  DATA_W          registered beat
//   fifo_write_rdy  in   1               FIFO can accept
//   grant_id        out  IDW             registered: current/last granted requester
//   busy            out  1               registered: FSM is in BURST
//
// Optional feature (macro FIFO_ARB_STATS_EN):
//   stats_clr       in   1               synchronous clear of beat counters
//   beat_count      out  NUM_REQ*16      saturating accepted-beat counter per requester
// -----------------------------------------------------------------------------
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned BURST_MAX = 4,
  localparam int unsigned IDW      = $clog2(NUM_REQ)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic                        fifo_write_en,
  output logic [DATA_W-1:0]           fifo_write_data,
  input  logic                        fifo_write_rdy,
  output logic [IDW-1:0]              grant_id,
`ifdef FIFO_ARB_STATS_EN
  input  logic                        stats_clr,
  output logic [NUM_REQ*16-1:0]       beat_count,
`endif
  output logic                        busy
);

  localparam int unsigned CNTW = $clog2(BURST_MAX + 1);

  arb_state_e          state_r;
  logic [IDW-1:0]      rr_ptr_r;
  logic [IDW-1:0]      grant_id_r;
  logic [CNTW-1:0]     burst_cnt_r;
  logic                busy_r;
  logic                wen_r;
  logic [DATA_W-1:0]   wdata_r;

  logic [IDW-1:0]      pick_idx_s;
  logic                pick_found_s;
  logic                sel_valid_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                out_free_s;
  logic                accept_s;
  logic                last_beat_s;
  logic                burst_end_s;
  logic [NUM_REQ-1:0]  req_ack_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_r),
    .idx    (pick_idx_s),
    .found  (pick_found_s)
  );

  // AND-OR mux of the granted requester's valid bit and data slice.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sel_valid_s = sel_valid_s | (req_valid[i] & (grant_id_r == IDW'(i)));
      sel_data_s  = sel_data_s  | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_id_r == IDW'(i)}});
    end
  end

  // Accept/burst-end decisions and the one-hot acknowledge.
  always_comb begin
    req_ack_s   = '0;
    // The stage can take a beat when empty or when its beat drains this cycle.
    out_free_s  = !wen_r || fifo_write_rdy;
    // Gated by RST so nothing is acknowledged in a cycle that discards state.
    accept_s    = !RST && (state_r == BURST) && sel_valid_s && out_free_s;
    last_beat_s = accept_s && (burst_cnt_r == CNTW'(BURST_MAX - 1));
    // A withdrawn request ends the burst even if the FIFO is stalling.
    burst_end_s = (state_r == BURST) && (last_beat_s || !sel_valid_s);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ack_s[i] = accept_s && (grant_id_r == IDW'(i));
    end
  end

  // Arbitration FSM with registered grant_id, busy, pointer and burst counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
      grant_id_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_id_r  <= pick_idx_s;
            burst_cnt_r <= '0;
            busy_r      <= 1'b1;
            state_r     <= BURST;
          end else begin
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        BURST: begin
          if (accept_s) begin
            burst_cnt_r <= burst_cnt_r + CNTW'(1'b1);
          end else begin
            burst_cnt_r <= burst_cnt_r;
          end
          if (burst_end_s) begin
            // The requester just served drops to lowest priority.
            rr_ptr_r <= IDW'(rr_next(32'(grant_id_r), NUM_REQ));
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end else begin
            busy_r   <= 1'b1;
            state_r  <= BURST;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // One-entry output stage; contents held stable while the FIFO is full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wen_r   <= 1'b0;
      wdata_r <= '0;
    end else if (accept_s) begin
      wen_r   <= 1'b1;
      wdata_r <= sel_data_s;
    end else if (wen_r && fifo_write_rdy) begin
      wen_r   <= 1'b0;
      wdata_r <= wdata_r;
    end else begin
      wen_r   <= wen_r;
      wdata_r <= wdata_r;
    end
  end

  assign req_ack         = req_ack_s;
  assign fifo_write_en   = wen_r;
  assign fifo_write_data = wdata_r;
  assign grant_id        = grant_id_r;
  assign busy            = busy_r;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] beat_cnt_r [NUM_REQ];

  // Per-requester saturating beat counters; clear wins over increment.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (RST || stats_clr) begin
        beat_cnt_r[i] <= 16'h0000;
      end else if (req_ack_s[i] && (beat_cnt_r[i] != 16'hFFFF)) begin
        beat_cnt_r[i] <= beat_cnt_r[i] + 16'h0001;
      end else begin
        beat_cnt_r[i] <= beat_cnt_r[i];
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    beat_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      beat_count[i*16 +: 16] = beat_cnt_r[i];
    end
  end
`endif

endmodule
